// File: rtl/divide_unit_pkg.sv
// Shared ALU definitions for the sequential divider: default width, FSM
// encoding and the divide-by-zero quotient fill bit.
package divide_unit_pkg;

  localparam int DIV_WIDTH = 8;

  // Every quotient bit is set when the divisor is zero.
  localparam logic DIV0_QUOT_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CALC   = 2'b01,
    ST_FINISH = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder with a full-adder ripple chain, restore on borrow.
module div_step
  import divide_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_sh,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (rem_sh[i]),
      .b  (~divisor[i]),
      .ci (carry[i]),
      .s  (diff[i]),
      .co (carry[i+1])
    );
  end

  // The top trial bit is rem_sh[WIDTH] + 1 + carry; it stays non-negative
  // when either the shifted-in MSB or the low-part carry covers the borrow.
  assign qbit     = rem_sh[WIDTH] | carry[WIDTH];
  assign rem_next = qbit ? diff : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the ALU ripple arithmetic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/divide_unit.sv
// Sequential unsigned restoring divider with start/busy/done handshake;
// one quotient bit per CALC cycle, MSB first.
module divide_unit
  import divide_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, q_q, d_q;
  logic             busy_d, done_d, accept;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_next, q_next;
  logic             qbit;

  // A's top bit is always zero between steps (remainder < divisor), so only
  // the low WIDTH bits are stored; the shift supplies the WIDTH+1-bit view.
  assign rem_sh = {a_q, q_q[WIDTH-1]};
  assign q_next = {q_q[WIDTH-2:0], qbit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_sh   (rem_sh),
    .divisor  (d_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_CALC: begin
        if (cnt_q == LAST) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          accept = 1'b1;
          if (data2 == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      if (accept) begin
        q_q      <= data1;
        d_q      <= data2;
        a_q      <= '0;
        cnt_q    <= '0;
        div_zero <= 1'b0;
        if (data2 == '0) begin
          quotient  <= {WIDTH{DIV0_QUOT_BIT}};
          remainder <= data1;
          div_zero  <= 1'b1;
        end
      end else if (state_q == ST_CALC) begin
        a_q   <= rem_next;
        q_q   <= q_next;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quotient  <= q_next;
          remainder <= rem_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Directed bench for divide_unit: reset, normal divisions, divide by zero,
// START while busy, reset abort and back-to-back starts.
module tb_divide_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data1 = '0, data2 = '0;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_zero;
  int         total = 0;
  int         bad = 0;

  divide_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .data1     (data1),
    .data2     (data2),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands with START for one edge; returns just after accept edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    data1 = a;
    data2 = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++;
    if ({quotient, remainder, busy, done, div_zero} !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs got q=%0d r=%0d b=%b d=%b z=%b want all 0",
               quotient, remainder, busy, done, div_zero);
    end
    reset_n = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_div(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er);
    launch(a, b);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s busy_phase@%0d got busy=%b done=%b want 1 0", name, i, busy, done);
      end
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || div_zero !== 1'b0) begin
      bad++;
      $display("FAIL %s done_flags got done=%b busy=%b dz=%b want 1 0 0", name, done, busy, div_zero);
    end
    total++;
    if (quotient !== eq || remainder !== er) begin
      bad++;
      $display("FAIL %s result got q=%0d r=%0d want q=%0d r=%0d", name, quotient, remainder, eq, er);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
      bad++;
      $display("FAIL %s after_done got done=%b busy=%b q=%0d r=%0d want 0 0 %0d %0d",
               name, done, busy, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_basic();
    test_div("d100_7", 8'd100, 8'd7, 8'd14, 8'd2);
    test_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0);
    test_div("d5_9", 8'd5, 8'd9, 8'd0, 8'd5);
    test_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0);
    test_div("d128_16", 8'd128, 8'd16, 8'd8, 8'd0);
  endtask

  task automatic test_div_zero();
    launch(8'd42, 8'd0);
    total++;
    if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL dz_flags got done=%b dz=%b busy=%b want 1 1 0", done, div_zero, busy);
    end
    total++;
    if (quotient !== 8'hFF || remainder !== 8'd42) begin
      bad++;
      $display("FAIL dz_result got q=%0d r=%0d want q=255 r=42", quotient, remainder);
    end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b1 || quotient !== 8'hFF) begin
      bad++;
      $display("FAIL dz_hold got done=%b busy=%b dz=%b q=%0d want 0 0 1 255",
               done, busy, div_zero, quotient);
    end
    test_div("after_dz", 8'd9, 8'd4, 8'd2, 8'd1);
  endtask

  task automatic test_busy_ignore();
    launch(8'd200, 8'd3);
    step();
    step();
    data1 = 8'd9;
    data2 = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL ign_busy got busy=%b done=%b want 1 0", busy, done);
    end
    for (int i = 0; i < 5; i++) step();
    total++;
    if (done !== 1'b1 || quotient !== 8'd66 || remainder !== 8'd2) begin
      bad++;
      $display("FAIL ign_result got done=%b q=%0d r=%0d want 1 66 2", done, quotient, remainder);
    end
    step();
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_no_second got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    data1 = 8'd100;
    data2 = 8'd7;
    start = 1'b1;
    for (int i = 0; i < 9; i++) step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      bad++;
      $display("FAIL b2b_first got done=%b busy=%b q=%0d r=%0d want 1 0 14 2",
               done, busy, quotient, remainder);
    end
    data1 = 8'd60;
    data2 = 8'd4;
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart got done=%b busy=%b want 0 1", done, busy);
    end
    for (int i = 0; i < 8; i++) step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 8'd15 || remainder !== 8'd0) begin
      bad++;
      $display("FAIL b2b_second got done=%b busy=%b q=%0d r=%0d want 1 0 15 0",
               done, busy, quotient, remainder);
    end
    start = 1'b0;
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    launch(8'd100, 8'd7);
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    total++;
    if ({quotient, remainder, busy, done, div_zero} !== 19'd0) begin
      bad++;
      $display("FAIL abort_async got q=%0d r=%0d b=%b d=%b z=%b want all 0",
               quotient, remainder, busy, done, div_zero);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet@%0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    test_div("post_abort", 8'd50, 8'd5, 8'd10, 8'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
